// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: decodes 10-bit SPI command frames and shares a single-port
// synchronous RAM with a local host port using round-robin arbitration.
module spi_ram_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter bit AUTO_INC  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [9:0]           rx_data,
   input  logic                 rx_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [ADDR_SIZE-1:0] host_addr,
   input  logic [7:0]           host_wdata,
   output logic                 host_gnt,
   output logic [7:0]           host_rdata,
   output logic                 host_rvalid,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ADDR_SIZE-1:0] ram_addr,
   output logic [7:0]           ram_wdata,
   input  logic [7:0]           ram_rdata,
   output logic                 spi_ovf
);
   typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;
   state_t state;
   logic rx_valid_q, spi_pend, spi_we, last_spi, cur_spi, cur_we;
   logic [ADDR_SIZE-1:0] wr_addr, rd_addr, spi_addr, payload;
   logic [7:0] spi_wdata;
   logic [1:0] op;
   logic rx_edge, acc_cmd, spi_sel, host_sel, accept;

   assign op       = rx_data[9:8];
   assign payload  = ADDR_SIZE'(rx_data[7:0]);
   assign rx_edge  = rx_valid & ~rx_valid_q;
   assign acc_cmd  = rx_edge & op[0];
   // with both requesters pending, the one not served last wins
   assign spi_sel  = (state == IDLE) & spi_pend & (~host_req | ~last_spi);
   assign host_sel = (state == IDLE) & host_req & ~spi_sel;
   assign accept   = acc_cmd & (~spi_pend | spi_sel);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rx_valid_q  <= 1'b0;
         spi_pend    <= 1'b0;
         spi_we      <= 1'b0;
         spi_addr    <= '0;
         spi_wdata   <= '0;
         wr_addr     <= '0;
         rd_addr     <= '0;
         last_spi    <= 1'b0;
         cur_spi     <= 1'b0;
         cur_we      <= 1'b0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         host_gnt    <= 1'b0;
         host_rdata  <= '0;
         host_rvalid <= 1'b0;
         ram_en      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         spi_ovf     <= 1'b0;
      end else begin
         rx_valid_q  <= rx_valid;
         host_gnt    <= 1'b0;
         host_rvalid <= 1'b0;
         spi_pend    <= accept | (spi_pend & ~spi_sel);
         if (rx_edge && op == 2'b00) wr_addr <= payload;
         if (rx_edge && op == 2'b10) rd_addr <= payload;
         if (rx_edge && op[1]) tx_valid <= 1'b0;
         if (acc_cmd && !accept) spi_ovf <= 1'b1;
         // the entry snapshots the address before any auto-increment
         if (accept) begin
            spi_we    <= ~op[1];
            spi_addr  <= op[1] ? rd_addr : wr_addr;
            spi_wdata <= rx_data[7:0];
            if (AUTO_INC && !op[1]) wr_addr <= wr_addr + ADDR_SIZE'(1);
            if (AUTO_INC && op[1]) rd_addr <= rd_addr + ADDR_SIZE'(1);
         end
         case (state)
            IDLE: begin
               if (spi_sel || host_sel) begin
                  ram_en    <= 1'b1;
                  ram_we    <= spi_sel ? spi_we : host_we;
                  ram_addr  <= spi_sel ? spi_addr : host_addr;
                  ram_wdata <= spi_sel ? spi_wdata : host_wdata;
                  cur_we    <= spi_sel ? spi_we : host_we;
                  cur_spi   <= spi_sel;
                  last_spi  <= spi_sel;
                  host_gnt  <= host_sel;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               ram_en <= 1'b0;
               ram_we <= 1'b0;
               state  <= cur_we ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
               if (cur_spi) begin
                  tx_data  <= ram_rdata;
                  tx_valid <= 1'b1;
               end else begin
                  host_rdata  <= ram_rdata;
                  host_rvalid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed bench for spi_ram_arbiter with a behavioural RAM,
// plus an AUTO_INC=1 instance fed from the same SPI stream.
module tb_spi_ram_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       host_req = 1'b0, host_we = 1'b0;
   logic [7:0] host_addr = '0, host_wdata = '0;
   logic [7:0] tx_data, host_rdata, ram_addr, ram_wdata;
   logic [7:0] ram_rdata = '0;
   logic       tx_valid, host_gnt, host_rvalid, ram_en, ram_we, spi_ovf;
   logic [7:0] i_tx_data, i_host_rdata, i_ram_addr, i_ram_wdata;
   logic       i_tx_valid, i_host_gnt, i_host_rvalid, i_ram_en, i_ram_we, i_spi_ovf;
   logic       zero = 1'b0;
   logic [7:0] zero8 = '0;
   logic [7:0] mem [256];
   int         en_cnt = 0, wr_cnt = 0, inc_cnt = 0;
   logic [7:0] last_waddr = '0, last_wdata = '0;
   logic [7:0] inc_addr [16], inc_dat [16];
   int         total = 0, bad = 0;
   int         b_en, b_wr, b_inc;

   always #5 clk = ~clk;

   spi_ram_arbiter #(.ADDR_SIZE(8), .AUTO_INC(1'b0)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .spi_ovf(spi_ovf));

   spi_ram_arbiter #(.ADDR_SIZE(8), .AUTO_INC(1'b1)) dut_inc (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(i_tx_data), .tx_valid(i_tx_valid),
      .host_req(zero), .host_we(zero), .host_addr(zero8), .host_wdata(zero8),
      .host_gnt(i_host_gnt), .host_rdata(i_host_rdata), .host_rvalid(i_host_rvalid),
      .ram_en(i_ram_en), .ram_we(i_ram_we), .ram_addr(i_ram_addr), .ram_wdata(i_ram_wdata),
      .ram_rdata(zero8), .spi_ovf(i_spi_ovf));

   // RAM model and access logs
   always @(posedge clk) begin
      if (ram_en === 1'b1) begin
         en_cnt <= en_cnt + 1;
         if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt        <= wr_cnt + 1;
            last_waddr    <= ram_addr;
            last_wdata    <= ram_wdata;
         end else ram_rdata <= mem[ram_addr];
      end
      if (i_ram_en === 1'b1 && i_ram_we === 1'b1) begin
         inc_addr[inc_cnt % 16] <= i_ram_addr;
         inc_dat[inc_cnt % 16]  <= i_ram_wdata;
         inc_cnt                <= inc_cnt + 1;
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] pl);
      rx_data  = {op, pl};
      rx_valid = 1'b1;
      step(4);
      rx_valid = 1'b0;
      step(2);
   endtask

   initial begin
      step(2);
      chk("rst_ram_en", ram_en, 1'b0);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_ovf", spi_ovf, 1'b0);
      chk("rst_gnt", host_gnt, 1'b0);
      chk("rst_rvalid", host_rvalid, 1'b0);
      rst = 1'b0;
      step(1);
      // one SPI write with a held rx_valid
      b_en = en_cnt;
      b_wr = wr_cnt;
      send(2'b00, 8'h3C);
      send(2'b01, 8'hA5);
      chk("wr_count", wr_cnt - b_wr, 1);
      chk("wr_en_cycles", en_cnt - b_en, 1);
      chk("wr_addr", last_waddr, 8'h3C);
      chk("wr_data", last_wdata, 8'hA5);
      // SPI read latency and tx_valid hold/clear
      send(2'b10, 8'h3C);
      rx_data  = {2'b11, 8'h00};
      rx_valid = 1'b1;
      step(2);
      chk("rd_ram_en", ram_en, 1'b1);
      chk("rd_ram_we", ram_we, 1'b0);
      chk("rd_ram_addr", ram_addr, 8'h3C);
      step(1);
      chk("rd_e2_tx_valid", tx_valid, 1'b0);
      step(1);
      chk("rd_e3_tx_valid", tx_valid, 1'b1);
      chk("rd_tx_data", tx_data, 8'hA5);
      rx_valid = 1'b0;
      step(4);
      chk("tx_hold", tx_valid, 1'b1);
      rx_data  = {2'b10, 8'h3C};
      rx_valid = 1'b1;
      step(1);
      chk("tx_clr", tx_valid, 1'b0);
      chk("tx_data_hold", tx_data, 8'hA5);
      rx_valid = 1'b0;
      step(2);
      // lone host write makes last_gnt=HOST
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h77;
      step(1);
      chk("hw_gnt", host_gnt, 1'b1);
      chk("hw_addr", ram_addr, 8'h20);
      host_req = 1'b0;
      step(3);
      // contention with last_gnt=HOST: SPI first
      send(2'b00, 8'h40);
      rx_data  = {2'b01, 8'h99};
      rx_valid = 1'b1;
      step(1);
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h5A;
      step(1);
      chk("spi_first_en", ram_en, 1'b1);
      chk("spi_first_addr", ram_addr, 8'h40);
      chk("spi_first_data", ram_wdata, 8'h99);
      chk("spi_first_nogt", host_gnt, 1'b0);
      step(1);
      chk("spi_first_nogt2", host_gnt, 1'b0);
      step(1);
      chk("host_second_gnt", host_gnt, 1'b1);
      chk("host_second_addr", ram_addr, 8'h10);
      chk("host_second_data", ram_wdata, 8'h5A);
      host_req = 1'b0;
      rx_valid = 1'b0;
      step(3);
      // contention with last_gnt=SPI: host first
      send(2'b01, 8'h55);
      rx_data  = {2'b01, 8'h66};
      rx_valid = 1'b1;
      step(1);
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h11; host_wdata = 8'hC3;
      step(1);
      chk("host_first_gnt", host_gnt, 1'b1);
      chk("host_first_addr", ram_addr, 8'h11);
      host_req = 1'b0;
      step(2);
      chk("spi_second_en", ram_en, 1'b1);
      chk("spi_second_addr", ram_addr, 8'h40);
      chk("spi_second_data", ram_wdata, 8'h66);
      rx_valid = 1'b0;
      step(3);
      // host read
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
      step(1);
      chk("hr_gnt", host_gnt, 1'b1);
      chk("hr_we", ram_we, 1'b0);
      host_req = 1'b0;
      step(1);
      chk("hr_gnt_pulse", host_gnt, 1'b0);
      chk("hr_e1_rvalid", host_rvalid, 1'b0);
      step(1);
      chk("hr_e2_rvalid", host_rvalid, 1'b1);
      chk("hr_rdata", host_rdata, 8'h5A);
      step(1);
      chk("hr_rvalid_pulse", host_rvalid, 1'b0);
      // auto-increment instance wraps from 0xFF
      b_inc = inc_cnt;
      send(2'b00, 8'hFF);
      send(2'b01, 8'h11);
      send(2'b01, 8'h22);
      send(2'b01, 8'h33);
      chk("inc_count", inc_cnt - b_inc, 3);
      chk("inc_addr0", inc_addr[b_inc % 16], 8'hFF);
      chk("inc_addr1", inc_addr[(b_inc + 1) % 16], 8'h00);
      chk("inc_addr2", inc_addr[(b_inc + 2) % 16], 8'h01);
      chk("inc_data2", inc_dat[(b_inc + 2) % 16], 8'h33);
      chk("noinc_addr", last_waddr, 8'hFF);
      // SPI read so tx_valid is high before the overflow/reset test
      send(2'b11, 8'h00);
      chk("rd2_tx_valid", tx_valid, 1'b1);
      chk("rd2_tx_data", tx_data, 8'hA5);
      // overflow while the host keeps the arbiter busy
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
      rx_data  = {2'b01, 8'h01};
      rx_valid = 1'b1;
      step(1);
      host_req = 1'b0;
      rx_valid = 1'b0;
      step(1);
      chk("ovf_before", spi_ovf, 1'b0);
      rx_data  = {2'b01, 8'h02};
      rx_valid = 1'b1;
      step(1);
      chk("ovf_set", spi_ovf, 1'b1);
      step(1);
      chk("ovf_kept_en", ram_en, 1'b1);
      chk("ovf_kept_data", ram_wdata, 8'h01);
      chk("ovf_kept_addr", ram_addr, 8'hFF);
      // asynchronous reset during ACCESS
      #1 rst = 1'b1;
      #1;
      chk("arst_ram_en", ram_en, 1'b0);
      chk("arst_ovf", spi_ovf, 1'b0);
      chk("arst_tx_valid", tx_valid, 1'b0);
      rx_valid = 1'b0;
      step(1);
      rst = 1'b0;
      step(3);
      chk("post_rst_ram_en", ram_en, 1'b0);
      chk("post_rst_ovf", spi_ovf, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
